// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus types and constants for the NES memory-map agents (sprite DMA, bus mux).
package nes_bus_pkg;

    localparam int NES_ADDR_W = 16;
    localparam int NES_DATA_W = 8;

    typedef logic [NES_ADDR_W-1:0] nes_addr_t;
    typedef logic [NES_DATA_W-1:0] nes_data_t;

    localparam nes_addr_t NES_OAM_DMA_ADDR = 16'h4014;
    localparam nes_addr_t NES_OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } oam_dma_state_e;

    // One master's view of the downstream bus.
    typedef struct packed {
        nes_addr_t addr;
        nes_data_t wdata;
        logic      ren;
        logic      wen;
    } bus_req_t;

endpackage

// File: rtl/nes_bus_mux.sv
// 2:1 bus master mux: the CPU owns the memory map unless the DMA engine is active.
module nes_bus_mux
    import nes_bus_pkg::*;
(
    input  logic     sel_dma_i,
    input  bus_req_t cpu_req_i,
    input  bus_req_t dma_req_i,
    output bus_req_t bus_req_o
);

    assign bus_req_o = sel_dma_i ? dma_req_i : cpu_req_i;

endmodule

// File: rtl/nes_oam_dma.sv
// Sprite DMA agent between the 6502 core and the memory map; a write to $4014 copies a page to OAMDATA.
// Optional feature: define OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN penalty (parity tracking).
module nes_oam_dma
    import nes_bus_pkg::*;
#(
    parameter nes_addr_t DMA_REG_ADDR  = NES_OAM_DMA_ADDR,
    parameter nes_addr_t OAM_DATA_ADDR = NES_OAMDATA_ADDR,
    parameter int        XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cyc_en,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    oam_dma_state_e state_q;
    nes_data_t      page_q;
    logic [7:0]     idx_q;
    nes_data_t      latch_q;
    logic           rdy_q;
    logic           busy_q;
`ifdef OAM_DMA_ALIGN_EN
    logic           parity_q;
`endif

    bus_req_t cpu_req;
    bus_req_t dma_req;
    bus_req_t bus_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            latch_q  <= '0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else if (cpu_cyc_en) begin
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
            case (state_q)
                IDLE: begin
                    if (cpu_wen && (cpu_addr_out == DMA_REG_ADDR)) begin
                        page_q  <= cpu_data_out;
                        idx_q   <= '0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= HALT;
                    end
                end
                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    state_q <= parity_q ? ALIGN : READ;
`else
                    state_q <= READ;
`endif
                end
                ALIGN: state_q <= READ;
                READ: begin
                    latch_q <= bus_rdata;
                    state_q <= WRITE;
                end
                WRITE: begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= READ;
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // HALT and ALIGN keep the DMA as master with both strobes low so the CPU is fully cut off.
    always_comb begin
        dma_req = '{addr: {page_q, idx_q}, wdata: latch_q, ren: 1'b0, wen: 1'b0};
        case (state_q)
            READ:  dma_req.ren = 1'b1;
            WRITE: begin
                dma_req.addr = OAM_DATA_ADDR;
                dma_req.wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_req = '{addr: cpu_addr_out, wdata: cpu_data_out, ren: cpu_ren, wen: cpu_wen};

    nes_bus_mux u_bus_mux (
        .sel_dma_i (busy_q),
        .cpu_req_i (cpu_req),
        .dma_req_i (dma_req),
        .bus_req_o (bus_req)
    );

    assign bus_addr    = bus_req.addr;
    assign bus_wdata   = bus_req.wdata;
    assign bus_ren     = bus_req.ren;
    assign bus_wen     = bus_req.wen;
    assign cpu_data_in = bus_rdata;
    assign rdy         = rdy_q;
    assign dma_busy    = busy_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: passthrough, full-page DMA, page $FF, mid-transfer reset, stall.
module tb_nes_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cyc_en;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_rdata;
    logic        dma_busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] rd_log [0:1023];
    logic [7:0]  wr_log [0:1023];
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic par_model = 1'b0;

    always #5 clk = ~clk;

    nes_oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_cyc_en   (cpu_cyc_en),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .cpu_ren      (cpu_ren),
        .cpu_wen      (cpu_wen),
        .cpu_data_in  (cpu_data_in),
        .rdy          (rdy),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ren      (bus_ren),
        .bus_wen      (bus_wen),
        .bus_rdata    (bus_rdata),
        .dma_busy     (dma_busy)
    );

    // Memory model: distinct, address-dependent contents so misordered copies show up.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[7:0] ^ a[15:8] ^ 8'h3C) + 8'(a[3:0]);
    endfunction

    assign bus_rdata = mem_f(bus_addr);

    // Bus monitor: a strobe is a real transaction only on a CPU-cycle enable.
    always @(negedge clk) begin
        if (cpu_cyc_en && !rst) begin
            if (bus_ren) begin
                if (rd_cnt < 1024) rd_log[rd_cnt] = bus_addr;
                rd_cnt++;
            end
            if (bus_wen && bus_addr == 16'h2004) begin
                if (wr_cnt < 1024) wr_log[wr_cnt] = bus_wdata;
                wr_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) par_model <= 1'b0;
        else if (cpu_cyc_en) par_model <= ~par_model;
    end

    task automatic cyc(input logic en);
        cpu_cyc_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr_out = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_ren      = 1'b0;
        cpu_wen      = 1'b0;
    endtask

    task automatic clear_logs();
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    // Expected halt length given parity during the HALT cycle.
    function automatic int exp_len(input logic halt_par);
`ifdef OAM_DMA_ALIGN_EN
        return halt_par ? 514 : 513;
`else
        return (halt_par === 1'bx) ? 0 : 513;
`endif
    endfunction

    task automatic start_dma(input logic [7:0] page, output int expect_cycles);
        clear_logs();
        cpu_addr_out = 16'h4014;
        cpu_data_out = page;
        cpu_wen      = 1'b1;
        cpu_ren      = 1'b0;
        cyc(1'b1);
        expect_cycles = exp_len(par_model);
        checks++;
        if (rdy !== 1'b0 || dma_busy !== 1'b1) begin
            failures++;
            $display("FAIL dma_start page=%02h: rdy=%b busy=%b, required rdy=0 busy=1", page, rdy, dma_busy);
        end
        // Hostile CPU traffic (including another $4014 write) must be ignored while halted.
        cpu_addr_out = 16'h4014;
        cpu_data_out = 8'h77;
        cpu_wen      = 1'b1;
        cpu_ren      = 1'b1;
    endtask

    task automatic wait_done(inout int n);
        while (rdy !== 1'b1 && n < 700) begin
            cyc(1'b1);
            n++;
        end
        cpu_idle();
    endtask

    task automatic check_copy(input logic [7:0] page, input int n, input int expect_cycles, input string name);
        int bad_rd;
        int bad_wr;
        logic [15:0] a;
        bad_rd = -1;
        bad_wr = -1;
        checks++;
        if (n !== expect_cycles) begin
            failures++;
            $display("FAIL %s halt_len: got %0d cycles, required %0d", name, n, expect_cycles);
        end
        checks++;
        if (rd_cnt !== 256 || wr_cnt !== 256) begin
            failures++;
            $display("FAIL %s counts: reads=%0d writes=%0d, required 256/256", name, rd_cnt, wr_cnt);
        end
        for (int i = 0; i < 256 && i < rd_cnt && i < wr_cnt; i++) begin
            a = {page, 8'(i)};
            if (bad_rd < 0 && rd_log[i] !== a) bad_rd = i;
            if (bad_wr < 0 && wr_log[i] !== mem_f(a)) bad_wr = i;
        end
        checks++;
        if (bad_rd >= 0) begin
            failures++;
            $display("FAIL %s read_addr[%0d]: got %04h, required %04h", name, bad_rd, rd_log[bad_rd], {page, 8'(bad_rd)});
        end
        checks++;
        if (bad_wr >= 0) begin
            failures++;
            $display("FAIL %s oam_data[%0d]: got %02h, required %02h", name, bad_wr, wr_log[bad_wr], mem_f({page, 8'(bad_wr)}));
        end
        checks++;
        if (dma_busy !== 1'b0 || rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s end_state: busy=%b rdy=%b, required busy=0 rdy=1", name, dma_busy, rdy);
        end
        $display("%s: page=%02h halt=%0d reads=%0d writes=%0d", name, page, n, rd_cnt, wr_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_cyc_en = 1'b0;
        cpu_idle();
        repeat (3) cyc(1'b1);
        cpu_addr_out = 16'h1234;
        cpu_ren = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1 || dma_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: rdy=%b busy=%b, required rdy=1 busy=0", rdy, dma_busy);
        end
        checks++;
        if (bus_addr !== 16'h1234 || bus_ren !== 1'b1 || bus_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_passthru: addr=%04h ren=%b wen=%b, required 1234/1/0", bus_addr, bus_ren, bus_wen);
        end
        rst = 1'b0;
        cpu_idle();
        cyc(1'b1);
        $display("reset: rdy=%b busy=%b", rdy, dma_busy);
    endtask

    task automatic test_passthrough();
        cpu_addr_out = 16'h0123;
        cpu_ren = 1'b1;
        cpu_wen = 1'b0;
        #1;
        checks++;
        if (bus_addr !== 16'h0123 || bus_ren !== 1'b1 || bus_wen !== 1'b0 || cpu_data_in !== mem_f(16'h0123)) begin
            failures++;
            $display("FAIL pass_read: addr=%04h ren=%b wen=%b rdata=%02h, required 0123/1/0/%02h",
                     bus_addr, bus_ren, bus_wen, cpu_data_in, mem_f(16'h0123));
        end
        cyc(1'b1);
        $display("pass read  $0123 -> %02h", cpu_data_in);
        cpu_addr_out = 16'h0200;
        cpu_data_out = 8'h5A;
        cpu_ren = 1'b0;
        cpu_wen = 1'b1;
        #1;
        checks++;
        if (bus_addr !== 16'h0200 || bus_wdata !== 8'h5A || bus_wen !== 1'b1 || bus_ren !== 1'b0) begin
            failures++;
            $display("FAIL pass_write: addr=%04h wdata=%02h wen=%b ren=%b, required 0200/5A/1/0",
                     bus_addr, bus_wdata, bus_wen, bus_ren);
        end
        cyc(1'b1);
        checks++;
        if (rdy !== 1'b1 || dma_busy !== 1'b0) begin
            failures++;
            $display("FAIL pass_rdy: rdy=%b busy=%b, required 1/0", rdy, dma_busy);
        end
        $display("pass write $0200 <- 5A");
        cpu_addr_out = 16'h0300;
        cpu_data_out = 8'hC3;
        cpu_ren = 1'b1;
        cpu_wen = 1'b1;
        #1;
        checks++;
        if (bus_ren !== 1'b1 || bus_wen !== 1'b1 || bus_wdata !== 8'hC3) begin
            failures++;
            $display("FAIL pass_both: ren=%b wen=%b wdata=%02h, required 1/1/C3", bus_ren, bus_wen, bus_wdata);
        end
        cyc(1'b1);
        cpu_idle();
        $display("pass read+write $0300");
    endtask

    task automatic test_dma_parity(input logic write_par, input string name);
        int n;
        int expect_cycles;
        if (par_model !== write_par) cyc(1'b1);
        start_dma(8'h02, expect_cycles);
        n = 0;
        wait_done(n);
        check_copy(8'h02, n, expect_cycles, name);
    endtask

    task automatic test_page_ff();
        int n;
        int expect_cycles;
        start_dma(8'hFF, expect_cycles);
        n = 0;
        wait_done(n);
        check_copy(8'hFF, n, expect_cycles, "page_ff");
        checks++;
        if (rd_cnt < 1 || rd_log[255] !== 16'hFFFF) begin
            failures++;
            $display("FAIL page_ff last_read: got %04h, required FFFF", rd_log[255]);
        end
        // After completion the agent must be back in passthrough, not reading $0000.
        cpu_idle();
        cyc(1'b1);
        cyc(1'b1);
        checks++;
        if (rd_cnt !== 256) begin
            failures++;
            $display("FAIL page_ff no_wrap: reads=%0d, required 256", rd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int expect_cycles;
        start_dma(8'h05, expect_cycles);
        n = 0;
        while (wr_cnt < 100 && n < 700) begin
            cyc(1'b1);
            n++;
        end
        rst = 1'b1;
        cpu_addr_out = 16'h1234;
        cpu_data_out = 8'h00;
        cpu_ren = 1'b1;
        cpu_wen = 1'b0;
        cyc(1'b1);
        checks++;
        if (rdy !== 1'b1 || dma_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid regs: rdy=%b busy=%b, required 1/0", rdy, dma_busy);
        end
        checks++;
        if (bus_addr !== 16'h1234 || bus_ren !== 1'b1 || bus_wen !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid passthru: addr=%04h ren=%b wen=%b, required 1234/1/0", bus_addr, bus_ren, bus_wen);
        end
        rst = 1'b0;
        repeat (6) cyc(1'b1);
        checks++;
        if (wr_cnt !== 100) begin
            failures++;
            $display("FAIL rst_mid oam_writes: got %0d, required 100", wr_cnt);
        end
        cpu_idle();
        $display("reset_mid: oam writes=%0d rdy=%b", wr_cnt, rdy);
    endtask

    task automatic test_stall();
        int n;
        int expect_cycles;
        int rd_before;
        int bad;
        logic [15:0] held_addr;
        start_dma(8'h03, expect_cycles);
        n = 0;
        while (!(bus_ren === 1'b1 && bus_addr === 16'h0332) && n < 700) begin
            cyc(1'b1);
            n++;
        end
        held_addr = bus_addr;
        rd_before = rd_cnt;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0);
            if (bus_addr !== held_addr || bus_ren !== 1'b1 || bus_wen !== 1'b0 || rdy !== 1'b0) bad++;
        end
        checks++;
        if (held_addr !== 16'h0332 || bad !== 0) begin
            failures++;
            $display("FAIL stall frozen: addr=%04h bad_clks=%0d, required 0332/0", held_addr, bad);
        end
        checks++;
        if (rd_cnt !== rd_before || rd_before !== 16'h32) begin
            failures++;
            $display("FAIL stall strobes: reads=%0d before=%0d, required 50/50", rd_cnt, rd_before);
        end
        wait_done(n);
        check_copy(8'h03, n, expect_cycles, "stall");
    endtask

    initial begin
        cpu_idle();
        cpu_cyc_en = 1'b0;
        rst = 1'b1;
        test_reset();
        test_passthrough();
        test_dma_parity(1'b0, "dma_even");
        test_dma_parity(1'b1, "dma_odd");
        test_page_ff();
        test_reset_mid();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
